// File: rtl/mux_nto1_arb_pkg.sv
// mux_arb_pkg: shared mode constants and helpers for the N:1 arbitrated mux
package mux_arb_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR = 1;
  localparam int MAX_BUS = 1024;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // Callers zero-extend the packed bus to MAX_BUS and truncate the result to W
  function automatic logic [MAX_BUS-1:0] slice(input logic [MAX_BUS-1:0] bus, input int i, input int w);
    return bus >> (i * w);
  endfunction
endpackage

// File: rtl/mux_nto1_arb_if.sv
// mux_nto1_arb_if: producer-side and consumer-side handshake bundle of the arbitrated mux
interface mux_nto1_arb_if import mux_arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int SW = clog2(N)
);
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic sel_en;
  logic [SW-1:0] sel;
  logic [W-1:0] z;
  logic [SW-1:0] z_src;
  logic z_valid;
  logic z_ready;
  modport master (output in_data, in_valid, sel_en, sel, z_ready, input in_ready, z, z_src, z_valid);
  modport slave (input in_data, in_valid, sel_en, sel, z_ready, output in_ready, z, z_src, z_valid);
endinterface

// File: rtl/mux_nto1_arb_pick.sv
// rr_priority_pick: first set request at or after ptr, wrapping, as one-hot, index and any flag
module rr_priority_pick import mux_arb_pkg::*; #(
  parameter int N = 4,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);
  logic [SW-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = SW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any = 1'b1;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/mux_nto1_arb.sv
// mux_nto1_arb: N-input registered mux with fixed/round-robin/forced arbitration and backpressure
module mux_nto1_arb import mux_arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int RR = MODE_RR,
  parameter int SW = clog2(N)
) (
  input logic clk,
  input logic rst,
  mux_nto1_arb_if.slave bus
);
  logic load, any, sel_ok;
  logic [N-1:0] req, gnt;
  logic [SW-1:0] ptr, idx;
  assign load = ~bus.z_valid | bus.z_ready;
  // An out-of-range forced select (non-power-of-2 N) masks every channel
  assign sel_ok = int'(bus.sel) < N;
  assign req = bus.sel_en ? (sel_ok ? bus.in_valid & (N'(1) << bus.sel) : '0) : bus.in_valid;
  rr_priority_pick #(.N(N), .SW(SW)) u_pick (
    .req(req),
    .ptr(RR == MODE_RR ? ptr : '0),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  assign bus.in_ready = (load & any & ~rst) ? gnt : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.z <= '0;
      bus.z_src <= '0;
      bus.z_valid <= 1'b0;
      ptr <= '0;
    end else if (load) begin
      bus.z_valid <= any;
      if (any) begin
        bus.z <= W'(slice(MAX_BUS'(bus.in_data), int'(idx), W));
        bus.z_src <= idx;
        if (RR == MODE_RR && !bus.sel_en) ptr <= (idx == SW'(N - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux_nto1_arb.sv
// tb_mux_nto1_arb: directed vector table plus hand sequences for RR, fixed and N=3 forced instances
module tb_mux_nto1_arb;
  logic clk = 1'b0;
  logic rst;
  int total = 0, passed = 0;
  always #5 clk = ~clk;

  mux_nto1_arb_if #(.N(4), .W(8)) ia ();
  mux_nto1_arb_if #(.N(4), .W(8)) ib ();
  mux_nto1_arb_if #(.N(3), .W(8)) ic ();
  mux_nto1_arb #(.N(4), .W(8), .RR(1)) ua (.clk(clk), .rst(rst), .bus(ia));
  mux_nto1_arb #(.N(4), .W(8), .RR(0)) ub (.clk(clk), .rst(rst), .bus(ib));
  mux_nto1_arb #(.N(3), .W(8), .RR(1)) uc (.clk(clk), .rst(rst), .bus(ic));

  typedef struct {
    logic [3:0] v;
    logic se;
    logic [1:0] sel;
    logic zr;
    logic [3:0] rdy;
    logic [7:0] z;
    logic [1:0] src;
    logic zv;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string n, input logic [7:0] z, input logic [1:0] src, input logic zv);
    chk({n, " z"}, 32'(ia.z), 32'(z));
    chk({n, " z_src"}, 32'(ia.z_src), 32'(src));
    chk({n, " z_valid"}, 32'(ia.z_valid), 32'(zv));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h1, 8'hA0, 2'd0, 1'b1};
    tbl[1]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h2, 8'hA1, 2'd1, 1'b1};
    tbl[2]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h4, 8'hA2, 2'd2, 1'b1};
    tbl[3]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h8, 8'hA3, 2'd3, 1'b1};
    tbl[4]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h1, 8'hA0, 2'd0, 1'b1};
    tbl[5]  = '{4'h0, 1'b0, 2'd0, 1'b1, 4'h0, 8'hA0, 2'd0, 1'b0};
    tbl[6]  = '{4'hF, 1'b1, 2'd2, 1'b1, 4'h4, 8'hA2, 2'd2, 1'b1};
    tbl[7]  = '{4'hF, 1'b1, 2'd2, 1'b1, 4'h4, 8'hA2, 2'd2, 1'b1};
    tbl[8]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h2, 8'hA1, 2'd1, 1'b1};
    tbl[9]  = '{4'hE, 1'b1, 2'd0, 1'b1, 4'h0, 8'hA1, 2'd1, 1'b0};
    tbl[10] = '{4'h9, 1'b0, 2'd0, 1'b1, 4'h8, 8'hA3, 2'd3, 1'b1};
    tbl[11] = '{4'h9, 1'b0, 2'd0, 1'b0, 4'h0, 8'hA3, 2'd3, 1'b1};
    tbl[12] = '{4'h9, 1'b0, 2'd0, 1'b1, 4'h1, 8'hA0, 2'd0, 1'b1};
    rst = 1'b1;
    ia.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ib.in_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    ic.in_data = {8'hC2, 8'hC1, 8'hC0};
    ia.in_valid = 4'hF; ib.in_valid = 4'hF; ic.in_valid = 3'b111;
    ia.sel_en = 1'b0; ib.sel_en = 1'b0; ic.sel_en = 1'b0;
    ia.sel = '0; ib.sel = '0; ic.sel = '0;
    ia.z_ready = 1'b1; ib.z_ready = 1'b1; ic.z_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1 chk("reset in_ready", 32'(ia.in_ready), 32'h0);
      step();
      chk("reset z_valid", 32'(ia.z_valid), 32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      ia.in_valid = tbl[i].v;
      ia.sel_en = tbl[i].se;
      ia.sel = tbl[i].sel;
      ia.z_ready = tbl[i].zr;
      #1 chk($sformatf("vec%0d in_ready", i), 32'(ia.in_ready), 32'(tbl[i].rdy));
      step();
      chk_a($sformatf("vec%0d", i), tbl[i].z, tbl[i].src, tbl[i].zv);
    end
    // backpressure after a word from channel 2
    ia.in_data[23:16] = 8'h5C;
    ia.in_valid = 4'h4;
    #1 chk("bp grant2", 32'(ia.in_ready), 32'h4);
    step();
    chk_a("bp load", 8'h5C, 2'd2, 1'b1);
    ia.z_ready = 1'b0;
    ia.in_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp stall in_ready", 32'(ia.in_ready), 32'h0);
      step();
      chk_a("bp hold", 8'h5C, 2'd2, 1'b1);
    end
    ia.z_ready = 1'b1;
    ia.in_data[23:16] = 8'hA2;
    #1 chk("bp resume in_ready", 32'(ia.in_ready), 32'h8);
    step();
    chk_a("bp resume", 8'hA3, 2'd3, 1'b1);
    #1 chk("bp next in_ready", 32'(ia.in_ready), 32'h1);
    step();
    chk_a("bp next", 8'hA0, 2'd0, 1'b1);
    // reset while stalled with a valid word held
    ia.z_ready = 1'b0;
    rst = 1'b1;
    #1 chk("rst stall in_ready", 32'(ia.in_ready), 32'h0);
    step();
    chk_a("rst stall", 8'h00, 2'd0, 1'b0);
    rst = 1'b0;
    ia.z_ready = 1'b1;
    #1 chk("post rst in_ready", 32'(ia.in_ready), 32'h1);
    step();
    chk_a("post rst", 8'hA0, 2'd0, 1'b1);
    // fixed priority instance
    do_reset();
    ib.in_valid = 4'hA;
    for (int c = 0; c < 3; c++) begin
      #1 chk("fix in_ready", 32'(ib.in_ready), 32'h2);
      step();
      chk("fix z", 32'(ib.z), 32'hB1);
      chk("fix z_src", 32'(ib.z_src), 32'd1);
    end
    ib.in_valid = 4'h8;
    #1 chk("fix ch3 in_ready", 32'(ib.in_ready), 32'h8);
    step();
    chk("fix ch3 z", 32'(ib.z), 32'hB3);
    chk("fix ch3 z_src", 32'(ib.z_src), 32'd3);
    // forced select on the N=3 instance
    ic.sel_en = 1'b1;
    ic.sel = 2'd2;
    do_reset();
    #1 chk("n3 force2 in_ready", 32'(ic.in_ready), 32'h4);
    step();
    chk("n3 force2 z", 32'(ic.z), 32'hC2);
    chk("n3 force2 z_src", 32'(ic.z_src), 32'd2);
    chk("n3 force2 z_valid", 32'(ic.z_valid), 32'd1);
    ic.sel = 2'd3;
    #1 chk("n3 sel3 in_ready", 32'(ic.in_ready), 32'h0);
    step();
    chk("n3 sel3 z_valid", 32'(ic.z_valid), 32'd0);
    chk("n3 sel3 z hold", 32'(ic.z), 32'hC2);
    ic.sel_en = 1'b0;
    #1 chk("n3 rr in_ready", 32'(ic.in_ready), 32'h1);
    step();
    chk("n3 rr z", 32'(ic.z), 32'hC0);
    chk("n3 rr z_src", 32'(ic.z_src), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
